// File: rtl/clu_pkg.sv
// Shared definitions for the CLU sequencer slice.
// Op-codes, FSM states and datapath widths.
package clu_pkg;

  localparam int DATA_W = 4;
  localparam int RPT_W  = 2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/clu_sequencer_clu.sv
// Single-step 4-bit combinational logic unit.
// Undefined codes yield zero; shifts move by one bit.
module clu_sequencer_clu
  import clu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        ctrl,
  output logic [DATA_W-1:0] y,
  output logic              zero,
  output logic              sign
);

  always_comb begin
    y = '0;
    case (ctrl)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      OP_SHL:  y = {a[DATA_W-2:0], 1'b0};
      OP_SHR:  y = {1'b0, a[DATA_W-1:1]};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);
  assign sign = y[DATA_W-1];

endmodule

// File: rtl/clu_sequencer.sv
// Round-robin front end sharing one CLU between two requesters,
// repeating each op rpt+1 times with the result fed back as A.
module clu_sequencer
  import clu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [2:0]        ctrl0,
  input  logic [RPT_W-1:0]  rpt0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic [2:0]        ctrl1,
  input  logic [RPT_W-1:0]  rpt1,
  output logic [1:0]        ack,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] result,
  output logic              zero_flag,
  output logic              sign_flag,
  output logic              busy
);

  state_t state, state_n;

  logic [DATA_W-1:0] acc, acc_n;
  logic [DATA_W-1:0] b_lat, b_lat_n;
  logic [2:0]        ctrl_lat, ctrl_lat_n;
  logic [RPT_W-1:0]  cnt, cnt_n;
  logic              owner, owner_n;
  logic              last_grant, last_grant_n;
  logic [1:0]        ack_n, done_n;
  logic [DATA_W-1:0] result_n;
  logic              zero_n, sign_n;
  logic              grant;

  logic [DATA_W-1:0] clu_y;
  logic              clu_zero, clu_sign;

  clu_sequencer_clu u_clu (
    .a    (acc),
    .b    (b_lat),
    .ctrl (ctrl_lat),
    .y    (clu_y),
    .zero (clu_zero),
    .sign (clu_sign)
  );

  // On contention the requester that did not win last time goes first
  assign grant = (&req) ? ~last_grant : req[1];
  assign busy  = (state != IDLE);

  always_comb begin
    state_n      = state;
    acc_n        = acc;
    b_lat_n      = b_lat;
    ctrl_lat_n   = ctrl_lat;
    cnt_n        = cnt;
    owner_n      = owner;
    last_grant_n = last_grant;
    ack_n        = 2'b00;
    done_n       = 2'b00;
    result_n     = result;
    zero_n       = zero_flag;
    sign_n       = sign_flag;
    unique case (state)
      IDLE: begin
        if (|req) begin
          acc_n        = grant ? a1 : a0;
          b_lat_n      = grant ? b1 : b0;
          ctrl_lat_n   = grant ? ctrl1 : ctrl0;
          cnt_n        = grant ? rpt1 : rpt0;
          owner_n      = grant;
          last_grant_n = grant;
          ack_n        = grant ? 2'b10 : 2'b01;
          state_n      = EXEC;
        end
      end
      EXEC: begin
        acc_n = clu_y;
        if (cnt == '0) begin
          result_n = clu_y;
          zero_n   = clu_zero;
          sign_n   = clu_sign;
          done_n   = owner ? 2'b10 : 2'b01;
          state_n  = RESP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      b_lat      <= '0;
      ctrl_lat   <= '0;
      cnt        <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      ack        <= 2'b00;
      done       <= 2'b00;
      result     <= '0;
      zero_flag  <= 1'b0;
      sign_flag  <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      b_lat      <= b_lat_n;
      ctrl_lat   <= ctrl_lat_n;
      cnt        <= cnt_n;
      owner      <= owner_n;
      last_grant <= last_grant_n;
      ack        <= ack_n;
      done       <= done_n;
      result     <= result_n;
      zero_flag  <= zero_n;
      sign_flag  <= sign_n;
    end
  end

endmodule

// File: tb/tb_clu_sequencer.sv
// Directed and randomized checks of clu_sequencer against
// a transaction-level model of arbitration, latency and results.
module tb_clu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] a0, b0, a1, b1;
  logic [2:0] ctrl0, ctrl1;
  logic [1:0] rpt0, rpt1;
  logic [1:0] ack, done;
  logic [3:0] result;
  logic       zero_flag, sign_flag, busy;

  int checks = 0;
  int errors = 0;
  int exp_last;

  clu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a0        (a0),
    .b0        (b0),
    .ctrl0     (ctrl0),
    .rpt0      (rpt0),
    .a1        (a1),
    .b1        (b1),
    .ctrl1     (ctrl1),
    .rpt1      (rpt1),
    .ack       (ack),
    .done      (done),
    .result    (result),
    .zero_flag (zero_flag),
    .sign_flag (sign_flag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_op(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic [2:0] c);
    int ai;
    ai = int'(a);
    case (c)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return 4'((ai * 2) % 16);
      3'd5: return 4'(ai / 2);
      default: return 4'd0;
    endcase
  endfunction

  task automatic transact(input logic [1:0] r, input bit hold,
                          output int g);
    logic [3:0] ea, eb, er;
    logic [2:0] ec;
    int rp, n;
    if (r == 2'b01) g = 0;
    else if (r == 2'b10) g = 1;
    else g = (exp_last == 0) ? 1 : 0;
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    ec = g ? ctrl1 : ctrl0;
    rp = g ? int'(rpt1) : int'(rpt0);
    er = ea;
    for (int i = 0; i <= rp; i++) er = ref_op(er, eb, ec);
    exp_last = g;
    req = r;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 2'b00 && n < 8);
    chk("ack", 32'(ack), g ? 32'd2 : 32'd1);
    chk("ack_lat", n, 1);
    chk("busy_exec", 32'(busy), 1);
    if (!hold) req = 2'b00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 2'b00 && n < 12);
    chk("done", 32'(done), g ? 32'd2 : 32'd1);
    chk("done_lat", n, rp + 1);
    chk("result", 32'(result), 32'(er));
    chk("zero", 32'(zero_flag), 32'(er == 4'd0));
    chk("sign", 32'(sign_flag), 32'(er[3]));
    @(negedge clk);
    chk("done_clr", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("ack_done_excl", 32'(|ack && |done), 0);
      chk("onehot", 32'($onehot0(ack) && $onehot0(done)), 1);
    end
  end

  initial begin
    int g;
    rst = 1'b1;
    req = 2'b00;
    a0 = 4'd0; b0 = 4'd0; ctrl0 = 3'd0; rpt0 = 2'd0;
    a1 = 4'd0; b1 = 4'd0; ctrl1 = 3'd0; rpt1 = 2'd0;
    exp_last = 1;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", 32'({zero_flag, sign_flag}), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    a0 = 4'b1010; b0 = 4'b0110; ctrl0 = 3'b010; rpt0 = 2'd0;
    transact(2'b01, 1'b0, g);
    chk("xor_res", 32'(result), 32'hC);
    chk("xor_flags", 32'({zero_flag, sign_flag}), 32'b01);

    a0 = 4'b0011; b0 = 4'b0000; ctrl0 = 3'b100; rpt0 = 2'd2;
    transact(2'b01, 1'b0, g);
    chk("shl_res", 32'(result), 32'h8);

    a1 = 4'b1000; b1 = 4'b0000; ctrl1 = 3'b101; rpt1 = 2'd3;
    transact(2'b10, 1'b0, g);
    chk("shr_res", 32'(result), 32'h0);
    chk("shr_zero", 32'(zero_flag), 1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_last = 1;
    a0 = 4'b1100; b0 = 4'b0101; ctrl0 = 3'b001; rpt0 = 2'd0;
    a1 = 4'b0110; b1 = 4'b0011; ctrl1 = 3'b000; rpt1 = 2'd0;
    for (int i = 0; i < 4; i++) begin
      transact(2'b11, 1'b1, g);
      chk("rr_grant", g, i % 2);
    end
    req = 2'b00;
    @(negedge clk);

    a0 = 4'b0101; b0 = 4'b0011; ctrl0 = 3'b001; rpt0 = 2'd3;
    req = 2'b01;
    @(negedge clk);
    chk("mid_ack", 32'(ack), 1);
    req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", 32'({ack, done, result, zero_flag, sign_flag}), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_done", 32'(done), 0);
    end
    rst = 1'b0;
    exp_last = 1;
    a1 = 4'b1111; b1 = 4'b0001; ctrl1 = 3'b010; rpt1 = 2'd1;
    transact(2'b11, 1'b0, g);
    chk("post_rst_grant", g, 0);

    a0 = 4'b1111; b0 = 4'b1111; ctrl0 = 3'b111; rpt0 = 2'd0;
    transact(2'b01, 1'b0, g);
    chk("undef_res", 32'(result), 0);
    chk("undef_zero", 32'(zero_flag), 1);

    for (int i = 0; i < 40; i++) begin
      a0 = 4'($urandom); b0 = 4'($urandom);
      ctrl0 = 3'($urandom); rpt0 = 2'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom);
      ctrl1 = 3'($urandom); rpt1 = 2'($urandom);
      transact(2'($urandom_range(1, 3)), 1'b0, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
